alu_ctrl_pipe: RTL and testbench
================================

Name: alu_ctrl_pipe

Overview:
- Registered, handshaked ALU-control stage for the RISC datapath. Sits between instruction decode and the ALU.
- Decodes {alu_op, opcode} into an ALU control code, flags illegal encodings, and holds multi-cycle ALU operations until their latency expires.
- Parametrised in opcode/control widths and in which codes are multi-cycle. Successor to the combinational ALU control decoder.

Parameters:
- ALUOP_W, 2, width of alu_op
- OP_W, 4, width of opcode
- CNT_W, 3, width of alu_cnt (number of ALU codes = 2**CNT_W)
- OP_BASE, 2, first opcode mapped to code 0 when alu_op selects R-type
- MC_MASK, 8'b1000_0000, bit k set means ALU code k is multi-cycle (width 2**CNT_W)
- MC_LAT, 4, cycles a multi-cycle op occupies before output is valid (>=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream has an op
- in_ready  out  1  stage can accept
- alu_op  in  ALUOP_W  class from main control
- opcode  in  OP_W  instruction opcode field
- out_valid  out  1  alu_cnt/illegal valid
- out_ready  in  1  ALU consumes result
- alu_cnt  out  CNT_W  registered ALU control code
- illegal  out  1  registered illegal-encoding flag
- busy  out  1  multi-cycle op in progress

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. On reset, out_valid=0, alu_cnt=0, illegal=0, busy=0, state=IDLE, counter=0. in_ready=1 while not in reset.
- Decode is combinational; the result is registered on accept.
  - alu_op=2'b10: code 0 (ADD), legal.
  - alu_op=2'b01: code 1 (SUB), legal.
  - alu_op=2'b00: if OP_BASE <= opcode <= OP_BASE+2**CNT_W-1, code = opcode-OP_BASE, legal. Otherwise code 0 and illegal=1.
  - alu_op=2'b11: code 0, illegal=1.
  - Subtraction is unsigned at OP_W bits, truncated to CNT_W.
- Accept: in_valid && in_ready.
- State machine:
  - IDLE: on accept of a single-cycle code, register result and go to VALID; out_valid=1 next cycle (latency 1). On accept of a multi-cycle code (MC_MASK[code]=1, legal only), register result, load counter=MC_LAT-1, busy=1, go to WAIT.
  - WAIT: out_valid=0, in_ready=0. Counter decrements each cycle. When it reaches 0, go to VALID and clear busy (total MC_LAT cycles accept-to-out_valid).
  - VALID: out_valid=1. Outputs are held stable until out_ready. in_ready = out_ready. On out_ready with no accept, go to IDLE. On out_ready with a simultaneous accept, overwrite the register and go to VALID or WAIT per the new code. This gives throughput 1/cycle for single-cycle ops.
- Illegal encodings are never multi-cycle. They complete with latency 1, illegal=1, alu_cnt=0.
- No output changes while out_valid && !out_ready.
- in_valid inputs are ignored while in_ready=0. Upstream must hold them.
- Reset mid-WAIT aborts the op, with no output produced.

Optional Feature:
- ALU_CTRL_STATS_EN
  - Defined: adds outputs op_count[15:0] and illegal_count[15:0]. Each increments on every output handshake (out_valid && out_ready); illegal_count only when illegal=1. Both saturate at 16'hFFFF and are cleared by rst.
  - Undefined: the ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package alu_ctrl_pkg:
  - ALU code constants ALU_ADD=0, ALU_SUB=1 … ALU_C7=7.
  - ALUOP constants ALUOP_RTYPE=2'b00, ALUOP_SUB=2'b01, ALUOP_ADD=2'b10.
  - State enum IDLE/WAIT/VALID.
- Sub-module alu_ctrl_decode: purely combinational {alu_op, opcode} -> {code, illegal, multi}. alu_ctrl_pipe holds the FSM, counter and output register.

Test Plan:
- Reset then alu_op=2'b10, opcode=4'h0, in_valid 1 cycle, out_ready=1 -> next cycle out_valid=1, alu_cnt=3'b000, illegal=0.
- Back-to-back R-type opcodes 4'h2..4'h8 each cycle, out_ready=1 -> alu_cnt=0..6 on consecutive cycles, in_ready stays 1.
- alu_op=2'b00, opcode=4'h9 (code 7, multi-cycle) -> busy=1 and in_ready=0 for 4 cycles; out_valid=1 with alu_cnt=3'b111 exactly 4 cycles after accept.
- alu_op=2'b11, or alu_op=2'b00 with opcode=4'hF or 4'h0 -> latency 1, alu_cnt=0, illegal=1.
- out_ready=0 for 5 cycles with out_valid=1 and in_valid held -> alu_cnt stable and in_ready=0. Raising out_ready accepts the next op in the same cycle.
- Assert rst at WAIT counter=2 -> outputs zero immediately; after release, a new ADD completes with latency 1 and no stale code appears.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU control codes, alu_op classes and pipe state encoding
package alu_ctrl_pkg;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_C2 = 3'd2;
  localparam logic [2:0] ALU_C3 = 3'd3;
  localparam logic [2:0] ALU_C4 = 3'd4;
  localparam logic [2:0] ALU_C5 = 3'd5;
  localparam logic [2:0] ALU_C6 = 3'd6;
  localparam logic [2:0] ALU_C7 = 3'd7;
  localparam logic [1:0] ALUOP_RTYPE = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_ADD = 2'b10;
  typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;
endpackage

// File: rtl/alu_ctrl_pipe_if.sv
// alu_ctrl_pipe_if: decode-side and ALU-side handshakes of the ALU control stage
// master = upstream/ALU side driving in_valid, alu_op, opcode, out_ready
// slave  = the stage driving in_ready, out_valid, alu_cnt, illegal, busy
// ALU_CTRL_STATS_EN adds op_count/illegal_count
interface alu_ctrl_pipe_if #(
  parameter int ALUOP_W = 2,
  parameter int OP_W = 4,
  parameter int CNT_W = 3
) ();
  logic in_valid;
  logic in_ready;
  logic [ALUOP_W-1:0] alu_op;
  logic [OP_W-1:0] opcode;
  logic out_valid;
  logic out_ready;
  logic [CNT_W-1:0] alu_cnt;
  logic illegal;
  logic busy;
`ifdef ALU_CTRL_STATS_EN
  logic [15:0] op_count;
  logic [15:0] illegal_count;
  modport master (output in_valid, alu_op, opcode, out_ready,
                  input in_ready, out_valid, alu_cnt, illegal, busy, op_count, illegal_count);
  modport slave (input in_valid, alu_op, opcode, out_ready,
                 output in_ready, out_valid, alu_cnt, illegal, busy, op_count, illegal_count);
`else
  modport master (output in_valid, alu_op, opcode, out_ready,
                  input in_ready, out_valid, alu_cnt, illegal, busy);
  modport slave (input in_valid, alu_op, opcode, out_ready,
                 output in_ready, out_valid, alu_cnt, illegal, busy);
`endif
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational {alu_op, opcode} -> {ALU code, illegal, multi-cycle}
// ports: alu_op_i, opcode_i in; code_o, illegal_o, multi_o out
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2,
  parameter int OP_W = 4,
  parameter int CNT_W = 3,
  parameter int OP_BASE = 2,
  parameter logic [2**CNT_W-1:0] MC_MASK = 8'b1000_0000
) (
  input  logic [ALUOP_W-1:0] alu_op_i,
  input  logic [OP_W-1:0]    opcode_i,
  output logic [CNT_W-1:0]   code_o,
  output logic               illegal_o,
  output logic               multi_o
);
  logic is_add, is_sub, r_ok;
  always_comb begin
    is_add = alu_op_i == ALUOP_W'(ALUOP_ADD);
    is_sub = alu_op_i == ALUOP_W'(ALUOP_SUB);
    // range checked in int so OP_BASE + 2**CNT_W - 1 may exceed the opcode width
    r_ok = alu_op_i == ALUOP_W'(ALUOP_RTYPE) && int'(opcode_i) >= OP_BASE
           && int'(opcode_i) <= OP_BASE + 2**CNT_W - 1;
    code_o = is_add ? CNT_W'(ALU_ADD) : is_sub ? CNT_W'(ALU_SUB)
           : r_ok ? CNT_W'(opcode_i - OP_W'(OP_BASE)) : '0;
    illegal_o = !(is_add || is_sub || r_ok);
    multi_o = !illegal_o && MC_MASK[code_o];
  end
endmodule

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered, handshaked ALU control stage holding multi-cycle ops
// ports: clk, rst (async, active-high), bus (alu_ctrl_pipe_if.slave)
// ALU_CTRL_STATS_EN adds saturating op_count/illegal_count on the bus
module alu_ctrl_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 2,
  parameter int OP_W = 4,
  parameter int CNT_W = 3,
  parameter int OP_BASE = 2,
  parameter logic [2**CNT_W-1:0] MC_MASK = 8'b1000_0000,
  parameter int MC_LAT = 4
) (
  input logic clk,
  input logic rst,
  alu_ctrl_pipe_if.slave bus
);
  localparam int LW = $clog2(MC_LAT);
  state_t state_q;
  logic [LW-1:0] cnt_q;
  logic [CNT_W-1:0] alu_cnt_q, dec_code;
  logic out_valid_q, illegal_q, busy_q, dec_ill, dec_multi, accept;
  alu_ctrl_decode #(
    .ALUOP_W(ALUOP_W), .OP_W(OP_W), .CNT_W(CNT_W), .OP_BASE(OP_BASE), .MC_MASK(MC_MASK)
  ) u_dec (
    .alu_op_i(bus.alu_op), .opcode_i(bus.opcode),
    .code_o(dec_code), .illegal_o(dec_ill), .multi_o(dec_multi)
  );
  assign bus.in_ready = !rst && (state_q == IDLE || (state_q == VALID && bus.out_ready));
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_cnt = alu_cnt_q;
  assign bus.illegal = illegal_q;
  assign bus.busy = busy_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      out_valid_q <= 1'b0;
      alu_cnt_q <= '0;
      illegal_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (accept) begin
      alu_cnt_q <= dec_code;
      illegal_q <= dec_ill;
      state_q <= dec_multi ? WAIT : VALID;
      out_valid_q <= !dec_multi;
      busy_q <= dec_multi;
      cnt_q <= dec_multi ? LW'(MC_LAT - 1) : '0;
    end else if (state_q == WAIT) begin
      // counter loaded with MC_LAT-1, so VALID lands MC_LAT edges after accept
      state_q <= cnt_q == '0 ? VALID : WAIT;
      out_valid_q <= cnt_q == '0;
      busy_q <= cnt_q != '0;
      cnt_q <= cnt_q == '0 ? '0 : cnt_q - 1'b1;
    end else if (state_q == VALID && bus.out_ready) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
    end
  end
`ifdef ALU_CTRL_STATS_EN
  logic [15:0] op_count_q, illegal_count_q;
  logic hs;
  assign hs = out_valid_q && bus.out_ready;
  assign bus.op_count = op_count_q;
  assign bus.illegal_count = illegal_count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_q <= '0;
      illegal_count_q <= '0;
    end else begin
      op_count_q <= hs && op_count_q != 16'hFFFF ? op_count_q + 16'd1 : op_count_q;
      illegal_count_q <= hs && illegal_q && illegal_count_q != 16'hFFFF ? illegal_count_q + 16'd1 : illegal_count_q;
    end
  end
`endif
endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// tb_alu_ctrl_pipe: directed self-checking bench with scoreboard for alu_ctrl_pipe
module tb_alu_ctrl_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_ctrl_pipe_if #(.ALUOP_W(2), .OP_W(4), .CNT_W(3)) bus ();
  alu_ctrl_pipe dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {logic [2:0] code; logic ill;} exp_t;
  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [1:0] op, input logic [3:0] opc);
    if (op == 2'b10) return '{code: 3'd0, ill: 1'b0};
    if (op == 2'b01) return '{code: 3'd1, ill: 1'b0};
    if (op == 2'b00 && opc >= 4'd2 && opc <= 4'd9) return '{code: 3'(opc - 4'd2), ill: 1'b0};
    return '{code: 3'd0, ill: 1'b1};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL sb_underflow observed=output expected=none");
        end else begin
          e = sb.pop_front();
          chk("sb_code", 32'(bus.alu_cnt), 32'(e.code));
          chk("sb_ill", 32'(bus.illegal), 32'(e.ill));
        end
      end
      if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.alu_op, bus.opcode));
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.alu_op = 2'b00;
    bus.opcode = 4'h0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_alu_cnt", 32'(bus.alu_cnt), 0);
    chk("rst_illegal", 32'(bus.illegal), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    bus.alu_op = 2'b10; bus.opcode = 4'h0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("add_valid", 32'(bus.out_valid), 1);
    chk("add_cnt", 32'(bus.alu_cnt), 0);
    chk("add_ill", 32'(bus.illegal), 0);
    tick();
    for (int i = 2; i <= 8; i++) begin
      bus.alu_op = 2'b00; bus.opcode = 4'(i); bus.in_valid = 1'b1;
      @(negedge clk);
      chk("b2b_in_ready", 32'(bus.in_ready), 1);
      if (i > 2) chk("b2b_cnt", 32'(bus.alu_cnt), 32'(i - 3));
      tick();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_last_cnt", 32'(bus.alu_cnt), 6);
    tick();
    bus.alu_op = 2'b00; bus.opcode = 4'h9; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mc_busy", 32'(bus.busy), 1);
      chk("mc_in_ready", 32'(bus.in_ready), 0);
      chk("mc_out_valid", 32'(bus.out_valid), 0);
      tick();
    end
    @(negedge clk);
    chk("mc_done_valid", 32'(bus.out_valid), 1);
    chk("mc_done_cnt", 32'(bus.alu_cnt), 7);
    chk("mc_done_busy", 32'(bus.busy), 0);
    tick();
    for (int k = 0; k < 3; k++) begin
      bus.alu_op = k == 0 ? 2'b11 : 2'b00;
      bus.opcode = k == 1 ? 4'hF : 4'h0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("ill_valid", 32'(bus.out_valid), 1);
      chk("ill_cnt", 32'(bus.alu_cnt), 0);
      chk("ill_flag", 32'(bus.illegal), 1);
      tick();
    end
    bus.out_ready = 1'b0;
    bus.alu_op = 2'b01; bus.opcode = 4'h0; bus.in_valid = 1'b1;
    tick();
    bus.alu_op = 2'b00; bus.opcode = 4'h5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_cnt", 32'(bus.alu_cnt), 1);
      chk("hold_in_ready", 32'(bus.in_ready), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("release_cnt", 32'(bus.alu_cnt), 3);
    chk("release_valid", 32'(bus.out_valid), 1);
    tick();
    bus.alu_op = 2'b00; bus.opcode = 4'h9; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("abort_busy_before", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_out_valid", 32'(bus.out_valid), 0);
    chk("abort_cnt", 32'(bus.alu_cnt), 0);
    chk("abort_ill", 32'(bus.illegal), 0);
    sb.delete();
    tick();
    rst = 1'b0;
    bus.alu_op = 2'b10; bus.opcode = 4'h9; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_abort_valid", 32'(bus.out_valid), 1);
    chk("post_abort_cnt", 32'(bus.alu_cnt), 0);
    chk("post_abort_busy", 32'(bus.busy), 0);
    tick();
    @(negedge clk);
    chk("idle_out_valid", 32'(bus.out_valid), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
